// File: rtl/shift_sched.sv
// shift_sched: loads a seed pattern, then applies a counted run of single-bit shifts with hold/done handshake.
// Optional build macro SHIFT_SCHED_ROTATE_EN turns zero-fill shifts into rotates.
`default_nettype none

module shift_sched #(
    parameter int WIDTH = 8,
    parameter int LEN_W = 4
) (
    input  logic             clk_i,
    input  logic             reset_ni,
    input  logic             start_i,
    input  logic             dir_i,
    input  logic [WIDTH-1:0] seed_i,
    input  logic [LEN_W-1:0] steps_i,
    input  logic             hold_i,
    output logic [WIDTH-1:0] count_o,
    output logic [LEN_W-1:0] steps_left_o,
    output logic             busy_o,
    output logic             done_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   count_q, count_d;
    logic [LEN_W-1:0]   steps_left_q, steps_left_d;
    logic               dir_q, dir_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [WIDTH-1:0]   shifted;

    // dir_q = 0 moves bits toward the MSB, 1 toward the LSB.
    always_comb begin
`ifdef SHIFT_SCHED_ROTATE_EN
        if (dir_q) shifted = {count_q[0], count_q[WIDTH-1:1]};
        else       shifted = {count_q[WIDTH-2:0], count_q[WIDTH-1]};
`else
        if (dir_q) shifted = {1'b0, count_q[WIDTH-1:1]};
        else       shifted = {count_q[WIDTH-2:0], 1'b0};
`endif
    end

    always_comb begin
        state_d      = state_q;
        count_d      = count_q;
        steps_left_d = steps_left_q;
        dir_d        = dir_q;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    count_d      = seed_i;
                    steps_left_d = steps_i;
                    dir_d        = dir_i;
                    state_d      = (steps_i != '0) ? SHIFT : DONE;
                end
            end
            SHIFT: begin
                if (!hold_i) begin
                    count_d      = shifted;
                    steps_left_d = steps_left_q - 1'b1;
                    if (steps_left_q == LEN_W'(1)) state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // Status flags are registered from the next state so they line up with it.
        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q      <= IDLE;
            count_q      <= '0;
            steps_left_q <= '0;
            dir_q        <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            steps_left_q <= steps_left_d;
            dir_q        <= dir_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    assign count_o      = count_q;
    assign steps_left_o = steps_left_q;
    assign busy_o       = busy_q;
    assign done_o       = done_q;

endmodule

`default_nettype wire

// File: tb/tb_shift_sched.sv
// Directed self-checking bench for shift_sched.
`default_nettype none

module tb_shift_sched;

    logic       clk;
    logic       reset_n;
    logic       start;
    logic       dir;
    logic [7:0] seed;
    logic [3:0] steps;
    logic       hold;
    logic [7:0] count;
    logic [3:0] steps_left;
    logic       busy;
    logic       done;

    int checks = 0;
    int errors = 0;

    shift_sched #(.WIDTH(8), .LEN_W(4)) dut (
        .clk_i        (clk),
        .reset_ni     (reset_n),
        .start_i      (start),
        .dir_i        (dir),
        .seed_i       (seed),
        .steps_i      (steps),
        .hold_i       (hold),
        .count_o      (count),
        .steps_left_o (steps_left),
        .busy_o       (busy),
        .done_o       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic [7:0] c, input logic [3:0] sl,
                           input logic b, input logic d);
        chk({tag, ".count"}, 32'(count), 32'(c));
        chk({tag, ".steps_left"}, 32'(steps_left), 32'(sl));
        chk({tag, ".busy"}, 32'(busy), 32'(b));
        chk({tag, ".done"}, 32'(done), 32'(d));
    endtask

    task automatic launch(input logic [7:0] s, input logic d, input logic [3:0] n);
        seed  = s;
        dir   = d;
        steps = n;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    logic [7:0] exp_l, exp_r, exp_rst;

    initial begin
`ifdef SHIFT_SCHED_ROTATE_EN
        exp_l   = 8'b0000_0011;
        exp_r   = 8'b1100_0000;
        exp_rst = 8'b1000_0001;
`else
        exp_l   = 8'b0000_0010;
        exp_r   = 8'b0100_0000;
        exp_rst = 8'b0000_0001;
`endif
        reset_n = 1'b0;
        start   = 1'b0;
        dir     = 1'b0;
        seed    = 8'h00;
        steps   = 4'd0;
        hold    = 1'b0;
        tick();
        tick();
        chk_out("reset", 8'h00, 4'd0, 1'b0, 1'b0);
        #2 reset_n = 1'b1;
        tick();

        // Basic left run of 3.
        launch(8'h01, 1'b0, 4'd3);
        chk_out("t1.k", 8'h01, 4'd3, 1'b1, 1'b0);
        tick(); chk_out("t1.k1", 8'h02, 4'd2, 1'b1, 1'b0);
        tick(); chk_out("t1.k2", 8'h04, 4'd1, 1'b1, 1'b0);
        tick(); chk_out("t1.k3", 8'h08, 4'd0, 1'b1, 1'b1);
        tick(); chk_out("t1.k4", 8'h08, 4'd0, 1'b0, 1'b0);

        // Single step, vacated/re-entering bit, both directions.
        launch(8'h81, 1'b0, 4'd1);
        tick(); chk_out("t2.left", exp_l, 4'd0, 1'b1, 1'b1);
        tick(); chk_out("t2.left.idle", exp_l, 4'd0, 1'b0, 1'b0);
        launch(8'h81, 1'b1, 4'd1);
        tick(); chk_out("t2.right", exp_r, 4'd0, 1'b1, 1'b1);
        tick();

        // Hold for two cycles after the second shift.
        launch(8'h01, 1'b0, 4'd4);
        tick(); chk_out("t3.k1", 8'h02, 4'd3, 1'b1, 1'b0);
        tick(); chk_out("t3.k2", 8'h04, 4'd2, 1'b1, 1'b0);
        hold = 1'b1;
        tick(); chk_out("t3.hold1", 8'h04, 4'd2, 1'b1, 1'b0);
        tick(); chk_out("t3.hold2", 8'h04, 4'd2, 1'b1, 1'b0);
        hold = 1'b0;
        tick(); chk_out("t3.k5", 8'h08, 4'd1, 1'b1, 1'b0);
        tick(); chk_out("t3.k6", 8'h10, 4'd0, 1'b1, 1'b1);
        hold = 1'b1;
        tick(); chk_out("t3.k7", 8'h10, 4'd0, 1'b0, 1'b0);
        hold = 1'b0;

        // Zero-step run: load only.
        launch(8'hA5, 1'b0, 4'd0);
        chk_out("t4.k", 8'hA5, 4'd0, 1'b1, 1'b1);
        tick(); chk_out("t4.k1", 8'hA5, 4'd0, 1'b0, 1'b0);

        // Starts mid-run and during DONE are ignored.
        launch(8'h01, 1'b0, 4'd2);
        seed = 8'hFF; dir = 1'b1; steps = 4'd5; start = 1'b1;
        tick(); start = 1'b0;
        chk_out("t5.k1", 8'h02, 4'd1, 1'b1, 1'b0);
        tick(); chk_out("t5.k2", 8'h04, 4'd0, 1'b1, 1'b1);
        start = 1'b1;
        tick(); start = 1'b0;
        chk_out("t5.k3", 8'h04, 4'd0, 1'b0, 1'b0);
        tick(); chk_out("t5.k4", 8'h04, 4'd0, 1'b0, 1'b0);

        // Asynchronous reset mid-shift, then a fresh run.
        launch(8'h01, 1'b0, 4'd5);
        tick(); chk_out("t6.k1", 8'h02, 4'd4, 1'b1, 1'b0);
        #2 reset_n = 1'b0;
        #1 chk_out("t6.async", 8'h00, 4'd0, 1'b0, 1'b0);
        #1 reset_n = 1'b1;
        tick(); chk_out("t6.idle", 8'h00, 4'd0, 1'b0, 1'b0);
        launch(8'h03, 1'b1, 4'd1);
        chk_out("t6.k", 8'h03, 4'd1, 1'b1, 1'b0);
        tick(); chk_out("t6.k1b", exp_rst, 4'd0, 1'b1, 1'b1);
        tick(); chk_out("t6.k2b", exp_rst, 4'd0, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/shift_sched.md
# shift_sched

Sequencer for the 8-bit shift-counter datapath. It accepts a one-cycle start request carrying a seed pattern, a direction and a step count. It then loads the pattern and applies exactly that many single-bit shifts, one per clock. Hold requests can pause shifting, and completion is signalled with a one-cycle done pulse. It sits between the command/control logic and the shift-register datapath, whose state it owns and presents on `count`.

## Interface
- `WIDTH`, 8: width of the shifted pattern (`count`, `seed`).
- `LEN_W`, 4: width of the step-count field; maximum run is 2^LEN_W-1 shifts.

- `clk`  in  1  system clock; all state changes on rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `start`  in  1  run request; sampled only in IDLE.
- `dir`  in  1  shift direction, latched at start: 0 = left (toward MSB), 1 = right (toward LSB).
- `seed`  in  WIDTH  pattern loaded into `count` at start.
- `steps`  in  LEN_W  number of shifts to perform, latched at start; 0 = load only.
- `hold`  in  1  pause; while high in SHIFT, no shift occurs and the step counter does not advance.
- `count`  out  WIDTH  current pattern (registered).
- `steps_left`  out  LEN_W  shifts remaining (registered).
- `busy`  out  1  high whenever state != IDLE.
- `done`  out  1  one-cycle pulse marking end of run.

## Operation
- Reset (reset = 0, asynchronous, takes effect immediately, including mid-run):
  - state = IDLE
  - `count` = 0, `steps_left` = 0, `busy` = 0, `done` = 0
  - latched `dir` = 0
- States are IDLE, SHIFT and DONE.
- IDLE:
  - `count` retains the last value.
  - On a clock edge with `start` = 1: `count` <= `seed`, `steps_left` <= `steps`, and `dir` is latched.
  - Next state is SHIFT if `steps` != 0, otherwise DONE.
- SHIFT, edge with `hold` = 0:
  - Shift `count` one bit in the latched direction; the vacated bit is 0 (see Configuration).
  - `steps_left` <= `steps_left` - 1.
  - If `steps_left` was 1, next state is DONE.
- SHIFT, edge with `hold` = 1: all registers hold and state stays SHIFT. `hold` may be asserted arbitrarily long.
- DONE: `done` = 1 for exactly this cycle; next edge goes to IDLE unconditionally.
- `start` outside IDLE (SHIFT or DONE) is ignored, not queued. `seed`, `steps` and `dir` changes outside IDLE have no effect.
- `hold` in IDLE or DONE is ignored.
- `steps_left` never wraps below 0. It reads 0 in DONE and IDLE after a completed run.

## Timing
- `start` accepted at edge k:
  - `count` = `seed` and `busy` = 1 after edge k.
  - Shifts occur at edges k+1 .. k+N, where N = `steps` and `hold` stays low.
  - `done` is high in the cycle after edge k+N; `busy` falls after edge k+N+1.
- Each high-`hold` cycle during SHIFT extends the run by exactly one cycle.
- `steps` = 0: `done` is high in the cycle after edge k; IDLE after k+1.
- Back-to-back: the earliest next accepted `start` is edge k+N+2, the first IDLE edge.
- All outputs are registers; there are no combinational paths from inputs to outputs.

## Configuration
- Macro `SHIFT_SCHED_ROTATE_EN`:
  - Defined: a shift is a rotate. On a left shift, the MSB re-enters at the LSB; on a right shift, the LSB re-enters at the MSB.
  - Undefined: zero-fill shift; the bit shifted out is discarded.
- No other behaviour differs between the two builds.

## Test plan
- Reset, then `seed` = 8'b0000_0001, `dir` = 0, `steps` = 3, `start` pulse at edge k:
  - `count` after k = 0000_0001, after k+3 = 0000_1000.
  - `done` is high in exactly one cycle, after k+3.
  - `busy` falls after k+4.
- `seed` = 8'b1000_0001, `dir` = 0, `steps` = 1:
  - Without the macro, `count` = 0000_0010.
  - With `SHIFT_SCHED_ROTATE_EN`, `count` = 0000_0011.
  - Repeat with `dir` = 1: expect 0100_0000 / 1100_0000.
- `steps` = 4 with `hold` high for 2 cycles after the second shift:
  - `count` and `steps_left` (= 2) stay frozen while `hold` is high.
  - `done` arrives 2 cycles later than unheld (after k+6).
- `steps` = 0, `seed` = 8'hA5:
  - `count` = A5 after k, `done` is high in the next cycle, and no shift occurs.
- Second `start` (`seed` = 8'hFF) pulsed mid-run and in the DONE cycle: ignored, and the first run completes unchanged.
- `reset` driven low asynchronously (between edges) mid-SHIFT: `count` = 0, `busy` = 0, `done` = 0 immediately. After release, a new `start` runs normally.
